// File: rtl/ro_freq_meter.sv
// ro_freq_meter: ring-oscillator frequency meter.
// Settles the oscillator, then counts its edges over a clk gate window.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   start         one-cycle request, honoured only when idle
//   osc_in        raw oscillator output (async to clk)
//   ro_en         oscillator enable (settle + measure)
//   busy          high whenever not idle
//   result_*      valid/ready result: edge count and saturation flag
//
// Build option: define RO_FREQ_METER_AVG_EN to average four
// back-to-back gate windows (sum in CNT_W+2 bits, then >> 2).
module ro_freq_meter #(
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             osc_in,
  output logic             ro_en,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CNT_W-1:0] result_count,
  output logic             result_ovf
);

  localparam int MAXC =
    (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES
                                  : SETTLE_CYCLES;
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] SET_LAST =
    TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST =
    TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             s1;
  logic             s2;
  logic             hist;
  logic             osc_rise;

  logic [TW-1:0]    tmr;
  logic             settle_end;
  logic             win_end;
  logic             last_win;
  logic             meas_end;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf;
  logic             ovf_nxt;

  logic [CNT_W-1:0] res_cnt_nxt;
  logic             res_ovf_nxt;

  // Two-flop synchronizer plus history flop; free-running so the
  // pipeline is already primed when the gate opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1   <= osc_in;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign osc_rise = s2 & ~hist;

  assign settle_end = (tmr == SET_LAST);
  assign win_end    = (tmr == GATE_LAST);
  assign meas_end   = (state == MEASURE) &
                      win_end & last_win;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_end) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (win_end && last_win) state_nxt = DONE;
      end
      DONE: begin
        if (result_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ro_en        = (state == SETTLE) |
                        (state == MEASURE);
  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

  // Phase timer: counts settle cycles, then each gate window.
  // It is left at zero on every exit, so IDLE needs no clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr <= '0;
    end else if ((state == SETTLE && settle_end) ||
                 (state == MEASURE && win_end)) begin
      tmr <= '0;
    end else if (ro_en) begin
      tmr <= tmr + TW'(1);
    end
  end

  // Saturating edge count including this cycle's edge, so an edge
  // in the final gate cycle still lands in the result.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (osc_rise) begin
      if (cnt == CNT_MAX) begin
        ovf_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == SETTLE && settle_end) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (state == MEASURE) begin
      if (win_end) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

`ifdef RO_FREQ_METER_AVG_EN
  logic [1:0]       win;
  logic [CNT_W+1:0] acc;
  logic [CNT_W+1:0] sum_nxt;
  logic             ovf_any;

  assign last_win    = (win == 2'd3);
  assign sum_nxt     = acc + {2'b00, cnt_nxt};
  assign res_cnt_nxt = sum_nxt[CNT_W+1:2];
  assign res_ovf_nxt = ovf_any | ovf_nxt;

  // Window index and running sum of the four saturated counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      win     <= 2'd0;
      acc     <= '0;
      ovf_any <= 1'b0;
    end else if (state == SETTLE && settle_end) begin
      win     <= 2'd0;
      acc     <= '0;
      ovf_any <= 1'b0;
    end else if (state == MEASURE && win_end) begin
      win     <= win + 2'd1;
      acc     <= sum_nxt;
      ovf_any <= res_ovf_nxt;
    end
  end
`else
  assign last_win    = 1'b1;
  assign res_cnt_nxt = cnt_nxt;
  assign res_ovf_nxt = ovf_nxt;
`endif

  // Result holds from DONE entry until the next measurement ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_count <= '0;
      result_ovf   <= 1'b0;
    end else if (meas_end) begin
      result_count <= res_cnt_nxt;
      result_ovf   <= res_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb_ro_freq_meter: directed bench for ro_freq_meter.
// Timestamp-based reference model plus literal expectations.
module tb_ro_freq_meter;

  localparam int G  = 100;
  localparam int S  = 16;
  localparam int CW = 4;
`ifdef RO_FREQ_METER_AVG_EN
  localparam int NW = 4;
`else
  localparam int NW = 1;
`endif
  localparam int LAT  = 1 + S + NW * G;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HN   = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          osc_in = 1'b0;
  logic          result_ready = 1'b0;
  logic          ro_en;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] result_count;
  logic          result_ovf;

  ro_freq_meter #(
    .GATE_CYCLES  (G),
    .SETTLE_CYCLES(S),
    .CNT_W        (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .osc_in      (osc_in),
    .ro_en       (ro_en),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .result_count(result_count),
    .result_ovf  (result_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Square-wave oscillator; period 0 means stuck low.
  int osc_period = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    if (osc_period == 0) begin
      ph = 0;
      osc_in = 1'b0;
    end else begin
      ph = (ph + 1) % osc_period;
      osc_in = (ph < osc_period / 2);
    end
  end

  int nvec = 0;
  int nerr = 0;
  int nres = 0;
  int t0 = 0;
  bit chk_en = 1'b0;

  bit osc_hist [HN];
  bit m_act = 1'b0;
  int m_t0 = 0;
  bit m_rstq = 1'b0;
  bit m_have = 1'b0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // Rising edge seen by the meter in cycle k: osc was 0 in k-3
  // and 1 in k-2. Each window saturates independently.
  function automatic void model_result(input int ts,
                                       output int c,
                                       output bit o);
    int ws;
    int acc;
    int raw;
    ws  = ts + 1 + S;
    acc = 0;
    o   = 1'b0;
    for (int w = 0; w < NW; w++) begin
      raw = 0;
      for (int k = ws + w * G; k < ws + (w + 1) * G; k++) begin
        if (osc_hist[(k - 2) % HN] && !osc_hist[(k - 3) % HN])
          raw++;
      end
      if (raw > CMAX) begin
        o   = 1'b1;
        raw = CMAX;
      end
      acc += raw;
    end
    c = (NW == 1) ? acc : acc / 4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int per);
    osc_period = per;
    tick();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic collect(input string nm,
                         input int exp_c,
                         input bit exp_o,
                         input int stall,
                         input bit chk_cyc,
                         input bit restart,
                         input int nxt_per);
    int en_n;
    int vc;
    bit found;
    en_n  = 0;
    vc    = 0;
    found = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (ro_en === 1'b1) en_n++;
      if (result_valid === 1'b1) begin
        found = 1'b1;
        vc = cyc;
        break;
      end
    end
    if (!found) begin
      nvec++;
      nerr++;
      $display("FAIL %s_timeout: no result_valid, expected at +%0d",
               nm, LAT);
    end else begin
      cmp({nm, "_latency"}, vc - t0, LAT);
      if (chk_cyc) cmp({nm, "_ro_en_cycles"}, en_n, LAT - 1);
      cmp({nm, "_count"}, result_count, exp_c);
      cmp({nm, "_ovf"}, result_ovf, exp_o);
      repeat (stall) @(negedge clk);
      if (stall > 0) begin
        cmp({nm, "_stall_count"}, result_count, exp_c);
        cmp({nm, "_stall_busy"}, busy, 1);
      end
      tick();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      if (restart) begin
        osc_period = nxt_per;
        start = 1'b1;
        t0 = cyc;
      end
      @(negedge clk);
      cmp({nm, "_idle_busy"}, busy, 0);
      cmp({nm, "_idle_valid"}, result_valid, 0);
      if (restart) begin
        tick();
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int vs;

    fork
      forever begin
        bit e_val;
        bit e_ro;
        @(negedge clk);
        osc_hist[cyc % HN] = osc_in;
        e_val = m_act && (cyc >= m_t0 + LAT);
        e_ro  = m_act && !e_val;
        if (chk_en) begin
          cmp("m_ro_en", ro_en, e_ro);
          cmp("m_busy", busy, m_act);
          cmp("m_valid", result_valid, e_val);
          if (e_val) begin
            if (!m_have) begin
              model_result(m_t0, m_cnt, m_ovf);
              m_have = 1'b1;
            end
            cmp("m_count", result_count, m_cnt);
            cmp("m_ovf", result_ovf, m_ovf);
          end
          if (m_rstq) begin
            cmp("m_rst_count", result_count, 0);
            cmp("m_rst_ovf", result_ovf, 0);
          end
          if (result_valid === 1'b1 && result_ready) nres++;
        end
        m_rstq = rst;
        if (rst) begin
          m_act = 1'b0;
        end else if (!m_act) begin
          if (start) begin
            m_act  = 1'b1;
            m_t0   = cyc;
            m_have = 1'b0;
          end
        end else if (e_val && result_ready) begin
          m_act = 1'b0;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("reset_ro_en", ro_en, 0);
    cmp("reset_busy", busy, 0);
    cmp("reset_valid", result_valid, 0);
    cmp("reset_count", result_count, 0);
    cmp("reset_ovf", result_ovf, 0);
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    result_ready = 1'b1;
    repeat (3) tick();
    result_ready = 1'b0;

    launch(10);
    collect("nominal", 10, 1'b0, 0, 1'b1, 1'b0, 0);

    launch(4);
    collect("sat", CMAX, 1'b1, 0, 1'b1, 1'b0, 0);

    launch(10);
    collect("stall", 10, 1'b0, 50, 1'b1, 1'b1, 0);
    collect("stuck", 0, 1'b0, 0, 1'b1, 1'b0, 0);

    launch(10);
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    collect("busy_start", 10, 1'b0, 0, 1'b0, 1'b0, 0);

    launch(10);
    repeat (60) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    cmp("midrst_ro_en", ro_en, 0);
    cmp("midrst_busy", busy, 0);
    cmp("midrst_valid", result_valid, 0);
    vs = 0;
    repeat (LAT + 50) begin
      @(negedge clk);
      if (result_valid !== 1'b0) vs++;
    end
    cmp("midrst_no_result", vs, 0);

    cmp("handshakes", nres, 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Measurement controller for the on-chip ring oscillator. It enables the oscillator, waits a settle interval, then counts oscillator rising edges over a fixed gate window of system clock cycles, and returns the count through a valid/ready result port. It sits between the ring oscillator instance and the lab control logic, and is the only block that drives the oscillator enable.

## Interface
- GATE_CYCLES, 1000: length of the measurement window in clk cycles (≥1).
- SETTLE_CYCLES, 16: clk cycles between enabling the oscillator and opening the window (≥4).
- CNT_W, 16: width of the edge counter and result.
- clk  input  1  system clock; all state is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle measurement request; sampled only in IDLE.
- osc_in  input  1  ring-oscillator output; asynchronous to clk.
- ro_en  output  1  oscillator enable.
- busy  output  1  high in every state except IDLE.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts the result.
- result_count  output  CNT_W  edge count for the window.
- result_ovf  output  1  the counter saturated during the window.

## Operation
- FSM states and transitions:
  - IDLE → SETTLE when start=1.
  - SETTLE → MEASURE after SETTLE_CYCLES cycles.
  - MEASURE → DONE after GATE_CYCLES cycles.
  - DONE → IDLE when result_valid & result_ready.
- ro_en is high in SETTLE and MEASURE and low otherwise.
- Input path: osc_in → 2-flop synchronizer → 1 history flop. A rising edge is detected when the sync output is 1 and the history flop is 0.
- The synchronizer and history flops reset to 0. They run continuously, so the pipeline is filled before MEASURE; SETTLE_CYCLES ≥ 4 guarantees this.
- Edge counter:
  - Cleared on entry to MEASURE.
  - Increments by 1 on each detected edge in a MEASURE cycle.
  - Saturates at 2^CNT_W−1; an edge at saturation sets an ovf flag.
- Accuracy: the count is correct only for osc frequency < f_clk/2. Faster oscillators alias; no detection is required.
- On entry to DONE, result_count and result_ovf are loaded and result_valid=1. They stay stable until the handshake completes.
- start is ignored outside IDLE (no queuing).

## Timing
- Reset values: ro_en=0, busy=0, result_valid=0, result_count=0, result_ovf=0; FSM in IDLE; all counters 0.
- Cycle T: start sampled high.
  - T+1: state SETTLE, ro_en=1, busy=1.
  - T+1+SETTLE_CYCLES: MEASURE.
  - T+1+SETTLE_CYCLES+GATE_CYCLES: DONE, result_valid=1, ro_en=0.
- Window: edges detected in exactly GATE_CYCLES consecutive MEASURE cycles are counted. Detection lags osc_in by 3 clk.
- Handshake:
  - When result_valid=1 and result_ready=1 on the same edge, the next cycle has result_valid=0 and busy=0 (IDLE).
  - start is accepted no earlier than that IDLE cycle.
  - result_ready while result_valid=0 has no effect.
- Reset mid-operation: the next edge returns every output to its reset value and aborts the measurement; no result is produced.
- Simultaneous edge and window close: an edge detected in the last MEASURE cycle is counted.

## Configuration
- Macro: RO_FREQ_METER_AVG_EN.
- When defined, averaging is enabled:
  - MEASURE runs 4 back-to-back windows of GATE_CYCLES with no gap.
  - The per-window saturating counts are summed in a CNT_W+2 accumulator.
  - result_count = accumulator >> 2 (truncated).
  - result_ovf = OR of the per-window ovf flags.
  - Latency grows to 1+SETTLE_CYCLES+4·GATE_CYCLES.
- When undefined: single window as described above; no accumulator is present.

## Test plan
- Nominal: GATE_CYCLES=100, SETTLE_CYCLES=16, osc_in square wave with period 10 clk, start pulse → result_valid at start+117, result_count=10, result_ovf=0, ro_en high for exactly 116 cycles.
- Saturation: CNT_W=4, GATE_CYCLES=100, osc period 4 clk → result_count=15, result_ovf=1.
- Handshake stall: result_ready held low for 50 cycles after result_valid → count/ovf stable and busy=1 throughout; ready pulse → IDLE next cycle, then a new start is accepted.
- Stuck oscillator: osc_in held 0 → result_count=0, result_ovf=0.
- Start while busy: second start pulse in SETTLE and in MEASURE → ignored; exactly one result is produced.
- Reset mid-MEASURE: rst for 1 cycle → next cycle ro_en=0, busy=0, result_valid=0, and no result appears later. With RO_FREQ_METER_AVG_EN and osc period 10, GATE_CYCLES=100 → result_count=10 at start+417.
